imem_loader: RTL and testbench

//  Write-side companion of the instruction memory. Receives a program image as a

---
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory image loader: packs a framed byte stream into 32-bit words,
// writes them at word-aligned byte addresses and holds the CPU until the checksum passes.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StLen, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    csum_d   = csum_q;
    rx_ready = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == 8'd0 || 32'(rx_data) > DEPTH) begin
            state_d = StErr;
          end else begin
            n_d     = rx_data;
            idx_d   = '0;
            bcnt_d  = '0;
            csum_d  = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          word_d = {word_q[23:0], rx_data};
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q + 8'd1 == n_q) ? StCsum : StData;
      end
      StCsum: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? StDone : StErr;
      end
      StDone, StErr: begin
        if (start) state_d = StLen;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state, so reset values hold asynchronously.
  assign wr_en    = (state_q == StWrite);
  assign wr_addr  = ADDR_W'(idx_q) << 2;
  assign wr_data  = word_q;
  assign cpu_hold = (state_q != StDone);
  assign done     = (state_q == StDone);
  assign err      = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and popped by a monitor whenever the loader strobes wr_en.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          strobes = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      strobes++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {wr_addr, wr_data}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[63:32]));
        check("wr_data", 64'(wr_data), 64'(e[31:0]));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Inputs change on the falling edge; a byte is consumed at the next rising edge
  // if rx_ready is high. Optionally injects idle gaps and stray start pulses.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit stray);
    bit ok = 0;
    while ($urandom_range(99) < gap_pct) begin
      rx_valid = 1'b0;
      start = stray && ($urandom_range(3) == 0);
      @(negedge clk);
      start = 1'b0;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_end();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || err) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("end_timeout", 64'd0, 64'd1);
  endtask

  // Sends a whole frame from img[]; bad_csum flips checksum bit 0.
  task automatic run_frame(input bit bad_csum, input int gap_pct, input bit stray);
    logic [7:0] cs = '0;
    logic [31:0] w;
    strobes = 0;
    pulse_start();
    check("hold_after_start", 64'(cpu_hold), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
    send_byte(8'(img.size()), gap_pct, stray);
    for (int k = 0; k < img.size(); k++) begin
      w = img[k];
      for (int j = 3; j >= 0; j--) begin
        cs ^= w[j*8 +: 8];
        if (j == 0) exp_q.push_back({32'(k * 4), w});
        send_byte(w[j*8 +: 8], gap_pct, stray);
      end
    end
    send_byte(cs ^ 8'(bad_csum), gap_pct, stray);
    wait_end();
  endtask

  task automatic bad_len(input logic [7:0] n);
    strobes = 0;
    pulse_start();
    send_byte(n, 0, 0);
    wait_end();
    check("badlen_err", 64'(err), 64'd1);
    check("badlen_done", 64'(done), 64'd0);
    check("badlen_hold", 64'(cpu_hold), 64'd1);
    check("badlen_strobes", 64'(strobes), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", 64'(rx_ready), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_addr", 64'(wr_addr), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: reset mid-DATA takes effect immediately
    pulse_start();
    send_byte(8'd2, 0, 0);
    send_byte(8'hE3, 0, 0);
    send_byte(8'hA0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", 64'(rx_ready), 64'd0);
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    check("midrst_hold", 64'(cpu_hold), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(rx_ready), 64'd0);

    // 2: two-word image
    img = '{32'hE3A00014, 32'hE3A01A01};
    run_frame(0, 0, 0);
    check("t2_done", 64'(done), 64'd1);
    check("t2_hold", 64'(cpu_hold), 64'd0);
    check("t2_err", 64'(err), 64'd0);
    check("t2_strobes", 64'(strobes), 64'd2);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: illegal lengths, then recovery
    bad_len(8'd0);
    bad_len(8'd65);

    // 4: checksum off by one bit
    img = '{32'h12345678};
    run_frame(1, 0, 0);
    check("t4_err", 64'(err), 64'd1);
    check("t4_done", 64'(done), 64'd0);
    check("t4_hold", 64'(cpu_hold), 64'd1);
    check("t4_strobes", 64'(strobes), 64'd1);

    // 5: random gaps and stray start pulses mid-frame
    img = '{32'hE3A00014, 32'hE3A01A01};
    run_frame(0, 40, 1);
    check("t5_done", 64'(done), 64'd1);
    check("t5_strobes", 64'(strobes), 64'd2);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // 6: full-depth image, then reload from DONE
    img = {};
    for (int k = 0; k < 64; k++) img.push_back($urandom());
    run_frame(0, 10, 0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_strobes", 64'(strobes), 64'd64);
    check("t6_last_addr", 64'(last_addr), 64'd252);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    img = '{32'hCAFEF00D};
    run_frame(0, 0, 0);
    check("reload_done", 64'(done), 64'd1);
    check("reload_strobes", 64'(strobes), 64'd1);
    check("reload_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
